// File: rtl/motor_pwm_sequencer.sv
// ESC arming sequencer and throttle slew limiter for four motor PWM channels.
// Drives time_work/period for each channel and applies the command timeout fallback.
module motor_pwm_sequencer #(
    parameter int unsigned PERIOD_US      = 20000,
    parameter int unsigned MIN_US         = 1000,
    parameter int unsigned MAX_US         = 2000,
    parameter int unsigned ARM_FRAMES     = 100,
    parameter int unsigned STEP_US        = 10,
    parameter int unsigned TIMEOUT_FRAMES = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        arm_req,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_motor,
    input  logic [15:0] cmd_value,
    output logic [31:0] period,
    output logic [31:0] time_work0,
    output logic [31:0] time_work1,
    output logic [31:0] time_work2,
    output logic [31:0] time_work3,
    output logic        frame_tick,
    output logic [1:0]  state,
    output logic        timeout
);

    // state | meaning
    // IDLE  | motors off, time_work = 0, waiting for arm_req at a frame tick
    // ARM   | MIN_US pulses for ARM_FRAMES frames so the ESCs arm
    // RUN   | commands accepted, duties slew toward targets once per frame
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    localparam logic [31:0] C_PERIOD   = 32'(PERIOD_US);
    localparam logic [31:0] C_LAST     = 32'(PERIOD_US - 1);
    localparam logic [15:0] C_MIN      = 16'(MIN_US);
    localparam logic [15:0] C_MAX      = 16'(MAX_US);
    localparam logic [15:0] C_STEP     = 16'(STEP_US);
    localparam logic [15:0] C_ARM_LAST = 16'(ARM_FRAMES - 1);
    localparam logic [15:0] C_TO       = 16'(TIMEOUT_FRAMES);
    localparam logic [15:0] C_TO_LAST  = 16'(TIMEOUT_FRAMES - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_frame_cnt, w_frame_cnt_nxt;
    logic        r_frame_tick;
    logic [15:0] r_arm_cnt, w_arm_cnt_nxt;
    logic [15:0] r_to_cnt, w_to_cnt_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic        r_cmd_ready;
    logic [15:0] r_target [4];
    logic [15:0] w_target_nxt [4];
    logic [15:0] r_duty [4];
    logic [15:0] w_duty_nxt [4];
    logic        w_accept;
    logic [15:0] w_cmd_clamped;

    function automatic logic [15:0] f_slew(input logic [15:0] d, input logic [15:0] t);
        logic [15:0] diff;
        if (t > d) begin
            diff = t - d;
            return d + ((diff > C_STEP) ? C_STEP : diff);
        end else if (t < d) begin
            diff = d - t;
            return d - ((diff > C_STEP) ? C_STEP : diff);
        end
        return d;
    endfunction

    assign w_frame_cnt_nxt = (r_frame_cnt == C_LAST) ? 32'd0 : r_frame_cnt + 32'd1;
    assign w_accept        = r_cmd_ready & cmd_valid;
    assign w_cmd_clamped   = (cmd_value < C_MIN) ? C_MIN :
                             (cmd_value > C_MAX) ? C_MAX : cmd_value;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_cnt  <= 32'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_frame_tick <= (w_frame_cnt_nxt == C_LAST);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= (w_state_nxt == ST_RUN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arm_cnt <= 16'd0;
            r_to_cnt  <= 16'd0;
            r_timeout <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_target[i] <= 16'd0;
                r_duty[i]   <= 16'd0;
            end
        end else begin
            r_arm_cnt <= w_arm_cnt_nxt;
            r_to_cnt  <= w_to_cnt_nxt;
            r_timeout <= w_timeout_nxt;
            for (int i = 0; i < 4; i++) begin
                r_target[i] <= w_target_nxt[i];
                r_duty[i]   <= w_duty_nxt[i];
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_arm_cnt_nxt = r_arm_cnt;
        w_to_cnt_nxt  = r_to_cnt;
        w_timeout_nxt = r_timeout;
        for (int i = 0; i < 4; i++) begin
            w_target_nxt[i] = r_target[i];
            w_duty_nxt[i]   = r_duty[i];
        end

        case (r_state)
            ST_IDLE: begin
                if (r_frame_tick && arm_req) begin
                    w_state_nxt   = ST_ARM;
                    w_arm_cnt_nxt = 16'd0;
                    for (int i = 0; i < 4; i++) w_duty_nxt[i] = C_MIN;
                end
            end
            ST_ARM: begin
                if (!arm_req) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_frame_tick) begin
                    if (r_arm_cnt == C_ARM_LAST) begin
                        w_state_nxt   = ST_RUN;
                        w_to_cnt_nxt  = 16'd0;
                        w_timeout_nxt = 1'b0;
                        for (int i = 0; i < 4; i++) w_target_nxt[i] = C_MIN;
                    end else begin
                        w_arm_cnt_nxt = r_arm_cnt + 16'd1;
                    end
                end
            end
            ST_RUN: begin
                if (!arm_req) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    // slew always uses the pre-command target on a shared tick
                    if (r_frame_tick) begin
                        for (int i = 0; i < 4; i++) w_duty_nxt[i] = f_slew(r_duty[i], r_target[i]);
                    end
                    if (w_accept) begin
                        w_target_nxt[cmd_motor] = w_cmd_clamped;
                        w_to_cnt_nxt            = 16'd0;
                        w_timeout_nxt           = 1'b0;
                    end else if (r_frame_tick && (r_to_cnt != C_TO)) begin
                        if (r_to_cnt == C_TO_LAST) begin
                            w_to_cnt_nxt  = C_TO;
                            w_timeout_nxt = 1'b1;
                            for (int i = 0; i < 4; i++) w_target_nxt[i] = C_MIN;
                        end else begin
                            w_to_cnt_nxt = r_to_cnt + 16'd1;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // leaving ARM/RUN drops the outputs at once, no ramp-down
        if (w_state_nxt == ST_IDLE) begin
            w_arm_cnt_nxt = 16'd0;
            w_to_cnt_nxt  = 16'd0;
            for (int i = 0; i < 4; i++) begin
                w_target_nxt[i] = 16'd0;
                w_duty_nxt[i]   = 16'd0;
            end
        end
    end

    assign period     = C_PERIOD;
    assign time_work0 = {16'd0, r_duty[0]};
    assign time_work1 = {16'd0, r_duty[1]};
    assign time_work2 = {16'd0, r_duty[2]};
    assign time_work3 = {16'd0, r_duty[3]};
    assign frame_tick = r_frame_tick;
    assign state      = r_state;
    assign timeout    = r_timeout;
    assign cmd_ready  = r_cmd_ready;

endmodule

// File: tb/tb_motor_pwm_sequencer.sv
// Directed bench for motor_pwm_sequencer with small frame/arming parameters.
// Expected values are hand-computed from the frame, ramp and timeout rules.
module tb_motor_pwm_sequencer;

    localparam int P_PERIOD = 100;
    localparam int P_MIN    = 20;
    localparam int P_MAX    = 80;
    localparam int P_ARM    = 4;
    localparam int P_STEP   = 10;
    localparam int P_TO     = 5;
    localparam int LIMIT    = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm_req;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_motor;
    logic [15:0] cmd_value;
    logic [31:0] period;
    logic [31:0] time_work0, time_work1, time_work2, time_work3;
    logic        frame_tick;
    logic [1:0]  state;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    motor_pwm_sequencer #(
        .PERIOD_US     (P_PERIOD),
        .MIN_US        (P_MIN),
        .MAX_US        (P_MAX),
        .ARM_FRAMES    (P_ARM),
        .STEP_US       (P_STEP),
        .TIMEOUT_FRAMES(P_TO)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .arm_req   (arm_req),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_motor (cmd_motor),
        .cmd_value (cmd_value),
        .period    (period),
        .time_work0(time_work0),
        .time_work1(time_work1),
        .time_work2(time_work2),
        .time_work3(time_work3),
        .frame_tick(frame_tick),
        .state     (state),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        if (obs !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_tick();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < LIMIT) begin
            step();
            n++;
        end
        chk("tick_seen", 32'(frame_tick), 1);
    endtask

    task automatic next_frame();
        to_tick();
        step();
    endtask

    task automatic send(input logic [1:0] m, input logic [15:0] v);
        cmd_valid = 1'b1;
        cmd_motor = m;
        cmd_value = v;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_tw(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_tw0"}, time_work0, 32'(e0));
        chk({tag, "_tw1"}, time_work1, 32'(e1));
        chk({tag, "_tw2"}, time_work2, 32'(e2));
        chk({tag, "_tw3"}, time_work3, 32'(e3));
    endtask

    task automatic arm_sequence(input string tag);
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < LIMIT) begin
            step();
            n++;
        end
        chk({tag, "_first_tick_cycles"}, 32'(n), 32'(P_PERIOD - 1));
        chk({tag, "_idle_before_tick"}, 32'(state), 0);
        step();
        chk({tag, "_tick_one_cycle"}, 32'(frame_tick), 0);
        chk({tag, "_arm_state"}, 32'(state), 1);
        chk({tag, "_arm_ready"}, 32'(cmd_ready), 0);
        chk_tw({tag, "_arm"}, P_MIN, P_MIN, P_MIN, P_MIN);
        for (int k = 1; k < P_ARM; k++) begin
            next_frame();
            chk({tag, "_still_arm"}, 32'(state), 1);
        end
        next_frame();
        chk({tag, "_run_state"}, 32'(state), 2);
        chk({tag, "_run_ready"}, 32'(cmd_ready), 1);
        chk_tw({tag, "_run"}, P_MIN, P_MIN, P_MIN, P_MIN);
    endtask

    initial begin
        reset     = 1'b0;
        arm_req   = 1'b1;
        cmd_valid = 1'b0;
        cmd_motor = 2'd0;
        cmd_value = 16'd0;

        // reset values
        #12;
        chk_tw("rst", 0, 0, 0, 0);
        chk("rst_period", period, 32'(P_PERIOD));
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        chk("rst_state", 32'(state), 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(negedge clk);
        reset = 1'b1;

        // 1: arming sequence
        arm_sequence("s1");

        // 2: motor 2 ramps to 55
        send(2'd2, 16'd55);
        next_frame(); chk_tw("s2_f1", 20, 20, 30, 20);
        next_frame(); chk_tw("s2_f2", 20, 20, 40, 20);
        next_frame(); chk_tw("s2_f3", 20, 20, 50, 20);
        next_frame(); chk_tw("s2_f4", 20, 20, 55, 20);
        chk("s2_timeout", 32'(timeout), 0);

        // 3: clamping, motors 1 and 3 ramp to 80 with keep-alive commands
        send(2'd0, 16'd5);
        send(2'd1, 16'd900);
        send(2'd3, 16'd80);
        for (int k = 1; k <= 7; k++) begin
            int e;
            e = (P_MIN + P_STEP * k > P_MAX) ? P_MAX : P_MIN + P_STEP * k;
            next_frame();
            chk_tw("s3_ramp", 20, e, 55, e);
            chk("s3_timeout", 32'(timeout), 0);
            send(2'd2, 16'd55);
        end

        // 4: timeout after 5 silent frames, then ramp down to MIN
        for (int k = 1; k <= P_TO; k++) begin
            next_frame();
            chk("s4_timeout_arm", 32'(timeout), 32'(k == P_TO));
            chk("s4_hold_tw3", time_work3, 80);
        end
        for (int k = 1; k <= 7; k++) begin
            int e3, e2;
            e3 = (80 - P_STEP * k < P_MIN) ? P_MIN : 80 - P_STEP * k;
            e2 = (55 - P_STEP * k < P_MIN) ? P_MIN : 55 - P_STEP * k;
            next_frame();
            chk_tw("s4_down", 20, e3, e2, e3);
            chk("s4_timeout_sticky", 32'(timeout), 1);
        end
        // command on a tick: clears timeout, slew on that tick uses old target
        to_tick();
        cmd_valid = 1'b1; cmd_motor = 2'd0; cmd_value = 16'd50;
        step();
        cmd_valid = 1'b0;
        chk("s4_cmd_clears_timeout", 32'(timeout), 0);
        chk("s4_old_target_on_tick", time_work0, 20);
        next_frame(); chk("s4_new_target_t1", time_work0, 30);
        next_frame(); chk("s4_t2", time_work0, 40);
        next_frame(); chk("s4_t3", time_work0, 50);
        next_frame(); chk("s4_t4", time_work0, 50);
        chk("s4_t4_timeout", 32'(timeout), 0);
        // command on the tick where timeout would trigger: command wins
        to_tick();
        cmd_valid = 1'b1; cmd_motor = 2'd0; cmd_value = 16'd60;
        step();
        cmd_valid = 1'b0;
        chk("s4_cmd_beats_timeout", 32'(timeout), 0);
        chk("s4_t5_tw0", time_work0, 50);
        next_frame();
        chk_tw("s4_after", 60, 20, 20, 20);
        chk("s4_after_timeout", 32'(timeout), 0);

        // 5: disarm in RUN drops outputs at once, commands ignored
        repeat (7) step();
        arm_req = 1'b0;
        step();
        chk("s5_state", 32'(state), 0);
        chk("s5_ready", 32'(cmd_ready), 0);
        chk_tw("s5_off", 0, 0, 0, 0);
        cmd_valid = 1'b1; cmd_motor = 2'd0; cmd_value = 16'd70;
        next_frame();
        cmd_valid = 1'b0;
        chk("s5_still_idle", 32'(state), 0);
        chk("s5_ready_low", 32'(cmd_ready), 0);
        chk_tw("s5_ignored", 0, 0, 0, 0);

        // 6: re-arm, then asynchronous reset between edges mid-RUN
        arm_req = 1'b1;
        next_frame();
        chk("s6_arm", 32'(state), 1);
        chk_tw("s6_arm", 20, 20, 20, 20);
        for (int k = 1; k < P_ARM; k++) next_frame();
        next_frame();
        chk("s6_run", 32'(state), 2);
        send(2'd0, 16'd80);
        next_frame(); chk("s6_tw0_a", time_work0, 30);
        next_frame(); chk("s6_tw0_b", time_work0, 40);
        #3;
        reset = 1'b0;
        #1;
        chk_tw("s6_async", 0, 0, 0, 0);
        chk("s6_async_state", 32'(state), 0);
        chk("s6_async_ready", 32'(cmd_ready), 0);
        chk("s6_async_tick", 32'(frame_tick), 0);
        chk("s6_async_timeout", 32'(timeout), 0);
        chk("s6_async_period", period, 32'(P_PERIOD));
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        arm_sequence("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
